// File: rtl/mic_peak_level_if.sv
// Measurement controls and result outputs of the mic peak-level meter.
// The meter side uses the slave modport; whatever drives it uses master.
interface mic_peak_level_if #(
    parameter int DATA_W  = 12,
    parameter int LEVEL_W = 4
);
    logic               en;
    logic               hold_en;
    logic [DATA_W-1:0]  mic_in;
    logic [DATA_W-1:0]  peak_out;
    logic [LEVEL_W-1:0] level_out;
    logic               level_valid;
    logic               busy;

    modport master (
        output en, hold_en, mic_in,
        input  peak_out, level_out, level_valid, busy
    );

    modport slave (
        input  en, hold_en, mic_in,
        output peak_out, level_out, level_valid, busy
    );
endinterface

// File: rtl/mic_peak_level.sv
// Windowed peak detector with a linear threshold-ladder quantiser and optional
// peak-hold with stepwise decay. Results arrive n+3 edges after a window closes.
module mic_peak_level #(
    parameter int DATA_W    = 12,
    parameter int LEVEL_W   = 4,
    parameter int WINDOW    = 4000,
    parameter int BASE      = 2300,
    parameter int STEP      = 75,
    parameter int DECAY_WIN = 8
) (
    input  logic            clk,
    input  logic            rst,
    mic_peak_level_if.slave bus
);
    localparam int CNT_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int THR_W  = DATA_W + LEVEL_W + 1;
    localparam int DCNT_W = $clog2(DECAY_WIN + 1);

    localparam logic [LEVEL_W-1:0] L_MAX     = '1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(WINDOW - 1);
    localparam logic [THR_W-1:0]   THR_BASE  = THR_W'(BASE);
    localparam logic [THR_W-1:0]   THR_STEP  = THR_W'(STEP);
    localparam logic [DCNT_W-1:0]  DCNT_LAST = DCNT_W'(DECAY_WIN - 1);

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_QUANT,
        ST_UPDATE
    } state_t;

    // Window accumulation
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_acc;
    logic [DATA_W-1:0]  r_pk;
    logic               r_close;
    logic [DATA_W-1:0]  w_max;

    // Quantiser
    state_t             r_state;
    state_t             w_state_nxt;
    logic [THR_W-1:0]   r_thr;
    logic [THR_W-1:0]   w_thr_nxt;
    logic [LEVEL_W-1:0] r_n;
    logic [LEVEL_W-1:0] w_n_nxt;
    logic               w_do_update;

    // Outputs and hold
    logic [DATA_W-1:0]  r_peak_out;
    logic [LEVEL_W-1:0] r_level_out;
    logic               r_level_valid;
    logic [DCNT_W-1:0]  r_dcnt;

    assign w_max = (bus.mic_in > r_acc) ? bus.mic_in : r_acc;

    // NOTE: every register in this file uses <= so that all blocks sample the
    // pre-edge values of each other's state, independent of evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_pk    <= '0;
            r_close <= 1'b0;
        end else begin
            r_close <= 1'b0;
            if (!bus.en) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_acc   <= '0;
                r_pk    <= w_max;
                r_close <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= w_max;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
            r_thr   <= '0;
            r_n     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_thr   <= w_thr_nxt;
            r_n     <= w_n_nxt;
        end
    end

    // NOTE: each signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_thr_nxt   = r_thr;
        w_n_nxt     = r_n;
        w_do_update = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                if (r_close) begin
                    w_state_nxt = ST_QUANT;
                    w_thr_nxt   = THR_BASE;
                    w_n_nxt     = '0;
                end
            end
            ST_QUANT: begin
                // One rung of the ladder per cycle; the wide threshold cannot wrap.
                if ((THR_W'(r_pk) >= r_thr) && (r_n != L_MAX)) begin
                    w_n_nxt   = r_n + 1'b1;
                    w_thr_nxt = r_thr + THR_STEP;
                end else begin
                    w_state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                w_do_update = 1'b1;
                w_state_nxt = ST_ACCUM;
            end
            default: begin
                w_state_nxt = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_peak_out    <= '0;
            r_level_out   <= '0;
            r_level_valid <= 1'b0;
            r_dcnt        <= '0;
        end else begin
            r_level_valid <= w_do_update;
            if (w_do_update) begin
                r_peak_out <= r_pk;
                if (!bus.hold_en || (r_n >= r_level_out)) begin
                    r_level_out <= r_n;
                    r_dcnt      <= '0;
                end else if (r_dcnt == DCNT_LAST) begin
                    // Held level is strictly above n here, so one step down stays >= n.
                    r_level_out <= r_level_out - 1'b1;
                    r_dcnt      <= '0;
                end else begin
                    r_dcnt <= r_dcnt + 1'b1;
                end
            end
        end
    end

    assign bus.peak_out    = r_peak_out;
    assign bus.level_out   = r_level_out;
    assign bus.level_valid = r_level_valid;
    assign bus.busy        = (r_state != ST_ACCUM);

endmodule

// File: tb/tb_mic_peak_level.sv
// Bench for mic_peak_level: three parameter variants share one stimulus stream;
// only the selected one is out of reset and compared against a window-level model.
module tb_mic_peak_level;
    localparam int BASE = 2300;
    localparam int STEP = 75;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_v;
    logic        en;
    logic        hold_en;
    logic [11:0] mic;
    int          sel;

    mic_peak_level_if #(.DATA_W(12), .LEVEL_W(4)) if0 ();
    mic_peak_level_if #(.DATA_W(12), .LEVEL_W(4)) if1 ();
    mic_peak_level_if #(.DATA_W(12), .LEVEL_W(3)) if2 ();

    assign if0.en = en;  assign if0.hold_en = hold_en;  assign if0.mic_in = mic;
    assign if1.en = en;  assign if1.hold_en = hold_en;  assign if1.mic_in = mic;
    assign if2.en = en;  assign if2.hold_en = hold_en;  assign if2.mic_in = mic;

    mic_peak_level #(.DATA_W(12), .LEVEL_W(4)) u_dut0 (
        .clk (clk), .rst (rst_v[0]), .bus (if0.slave)
    );
    mic_peak_level #(.DATA_W(12), .LEVEL_W(4), .WINDOW(40), .DECAY_WIN(2)) u_dut1 (
        .clk (clk), .rst (rst_v[1]), .bus (if1.slave)
    );
    mic_peak_level #(.DATA_W(12), .LEVEL_W(3), .WINDOW(20)) u_dut2 (
        .clk (clk), .rst (rst_v[2]), .bus (if2.slave)
    );

    logic [3:0]  obs_level;
    logic [11:0] obs_peak;
    logic        obs_valid;
    logic        obs_busy;

    always_comb begin
        case (sel)
            0: begin
                obs_level = if0.level_out;  obs_peak = if0.peak_out;
                obs_valid = if0.level_valid; obs_busy = if0.busy;
            end
            1: begin
                obs_level = if1.level_out;  obs_peak = if1.peak_out;
                obs_valid = if1.level_valid; obs_busy = if1.busy;
            end
            default: begin
                obs_level = {1'b0, if2.level_out}; obs_peak = if2.peak_out;
                obs_valid = if2.level_valid;      obs_busy = if2.busy;
            end
        endcase
    end

    int win_a  [3] = '{4000, 40, 20};
    int lmax_a [3] = '{15, 15, 7};
    int dwin_a [3] = '{8, 2, 8};

    int tests = 0;
    int fails = 0;

    // Reference model state: what the meter should be showing, and the one
    // window result that is still on its way through the quantiser.
    int m_cnt, m_wmax;
    int m_pend, m_pend_cnt, m_pend_n, m_pend_pk;
    int m_level, m_peak, m_valid, m_dcnt;

    function automatic int ladder_level(input int pk, input int lmax);
        int n = 0;
        for (int k = 0; k < lmax; k++)
            if (BASE + k * STEP <= pk) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d t=%0t: observed %0d expected %0d", tag, sel, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_wmax = 0; m_pend = 0; m_pend_cnt = 0; m_pend_n = 0; m_pend_pk = 0;
        m_level = 0; m_peak = 0; m_valid = 0; m_dcnt = 0;
    endtask

    task automatic model_publish();
        m_peak = m_pend_pk;
        if (!hold_en || m_pend_n >= m_level) begin
            m_level = m_pend_n;
            m_dcnt  = 0;
        end else begin
            m_dcnt++;
            if (m_dcnt == dwin_a[sel]) begin
                m_dcnt  = 0;
                m_level = (m_level - 1 < m_pend_n) ? m_pend_n : m_level - 1;
            end
        end
    endtask

    // One clock: drive a sample, let the edge pass, advance the model, compare.
    task automatic step(input logic [11:0] s);
        mic = s;
        @(posedge clk);
        #1;
        m_valid = 0;
        if (rst_v[sel]) begin
            model_reset();
        end else begin
            if (m_pend != 0) begin
                m_pend_cnt--;
                if (m_pend_cnt == 0) begin
                    m_pend  = 0;
                    m_valid = 1;
                    model_publish();
                end
            end
            if (!en) begin
                m_cnt = 0; m_wmax = 0;
            end else begin
                if (int'(s) > m_wmax) m_wmax = int'(s);
                m_cnt++;
                if (m_cnt == win_a[sel]) begin
                    m_pend_pk  = m_wmax;
                    m_pend_n   = ladder_level(m_wmax, lmax_a[sel]);
                    m_pend_cnt = m_pend_n + 3;
                    m_pend     = 1;
                    m_cnt      = 0;
                    m_wmax     = 0;
                end
            end
        end
        check("level_valid", obs_valid, m_valid);
        check("level_out", obs_level, m_level);
        check("peak_out", obs_peak, m_peak);
        if (m_pend != 0 && m_pend_cnt == 1) check("busy_update", obs_busy, 1);
        else if (m_pend == 0) check("busy_idle", obs_busy, 0);
    endtask

    task automatic select_dut(input int s);
        sel     = s;
        rst_v   = 3'b111;
        en      = 1'b0;
        hold_en = 1'b0;
        step(12'd0);
        step(12'd0);
        rst_v[s] = 1'b0;
        step(12'd0);
    endtask

    task automatic run_window(input int base_v, input int spike_v, input int spike_pos);
        for (int k = 0; k < win_a[sel]; k++)
            step(12'((k == spike_pos) ? spike_v : base_v));
    endtask

    task automatic run_random_window();
        int ceil_v;
        ceil_v = $urandom_range(3600, 2100);
        for (int k = 0; k < win_a[sel]; k++)
            step(12'($urandom_range(ceil_v, 0)));
    endtask

    task automatic flush(input int n);
        for (int k = 0; k < n; k++) step(12'd0);
    endtask

    initial begin
        rst_v   = 3'b111;
        en      = 1'b0;
        hold_en = 1'b0;
        mic     = 12'd0;
        sel     = 0;
        model_reset();

        // Default parameters: first-window latency, ladder edges, spikes.
        select_dut(0);
        en = 1'b1;
        run_window(2300, 0, -1);
        run_window(0, 0, -1);
        run_window(2299, 0, -1);
        run_window(3349, 0, -1);
        run_window(3350, 0, -1);
        run_window(4095, 0, -1);
        run_window(2000, 2600, 1999);
        run_window(2000, 0, -1);
        run_window(2000, 3000, 3999);
        run_window(2000, 0, -1);
        flush(20);

        // Short window, two-window decay: hold behaviour and random windows.
        select_dut(1);
        en      = 1'b1;
        hold_en = 1'b1;
        run_window(3000, 0, -1);
        repeat (5) run_window(0, 0, -1);
        run_window(2600, 0, -1);
        repeat (4) run_window(0, 0, -1);
        repeat (30) begin
            hold_en = 1'($urandom_range(1, 0));
            run_random_window();
        end

        // Partial window discarded when en drops, then a clean window.
        hold_en = 1'b0;
        flush(40);
        for (int k = 0; k < 17; k++) step(12'd3400);
        en = 1'b0;
        step(12'd3400);
        step(12'd3400);
        en = 1'b1;
        run_window(2450, 0, -1);
        flush(10);

        // en dropped while the quantiser is working: result still published.
        run_window(3300, 0, -1);
        en = 1'b0;
        flush(25);
        en = 1'b1;

        // Reset during quantisation: no pulse, outputs cleared.
        run_window(3300, 0, -1);
        step(12'd0);
        step(12'd0);
        rst_v[1] = 1'b1;
        step(12'd0);
        rst_v[1] = 1'b0;
        flush(45);

        // Narrow level (LMAX = 7) with a 20-cycle window.
        select_dut(2);
        en = 1'b1;
        run_window(2300, 0, -1);
        run_window(0, 0, -1);
        run_window(2299, 0, -1);
        run_window(3349, 0, -1);
        run_window(3350, 0, -1);
        run_window(4095, 0, -1);
        repeat (10) run_random_window();
        flush(25);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
